// File: rtl/pool2d_pkg.sv
// Shared types and constants for the 2-D pooling engine.
package pool2d_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DIM_WIDTH  = 8;
  localparam int ACC_WIDTH      = DEF_DATA_WIDTH + 2 * DEF_DIM_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Room for K*K <= 2^(2*DIM) signed elements without overflow.
  function automatic int acc_width(input int data_w, input int dim_w);
    return data_w + 2 * dim_w;
  endfunction

endpackage

// File: rtl/pool2d_engine_acc.sv
// Window accumulator: running signed max or wide signed sum, scaled on output.
module pool_window_acc
  import pool2d_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  en,
  input  logic                  first,
  input  logic                  mode,
  input  logic [4:0]            shift,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int ACC_W = acc_width(DATA_WIDTH, DIM_WIDTH);

  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      data_ext;
  logic signed [DATA_WIDTH-1:0] data_s;
  logic signed [DATA_WIDTH-1:0] acc_lo;

  function automatic logic [DATA_WIDTH-1:0] avg_scale(input logic signed [ACC_W-1:0] sum,
                                                      input logic [4:0] sh);
    return DATA_WIDTH'(sum >>> sh);
  endfunction

  assign data_s   = data;
  assign data_ext = {{(ACC_W - DATA_WIDTH){data[DATA_WIDTH-1]}}, data};
  assign acc_lo   = acc[DATA_WIDTH-1:0];

  // The first element of each window loads directly, so max never sees a zero seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      if (first) begin
        acc <= data_ext;
      end else if (mode == POOL_AVG) begin
        acc <= acc + data_ext;
      end else if (data_s > acc_lo) begin
        acc <= data_ext;
      end
    end
  end

  assign result = (mode == POOL_AVG) ? avg_scale(acc, shift) : acc[DATA_WIDTH-1:0];

endmodule

// File: rtl/pool2d_engine.sv
// Multi-channel max/average pooling engine with one-outstanding-read memory handshakes.
module pool2d_engine
  import pool2d_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DIM_WIDTH-1:0]  pool_size,
  input  logic [DIM_WIDTH-1:0]  stride,
  input  logic [DIM_WIDTH-1:0]  in_h,
  input  logic [DIM_WIDTH-1:0]  in_w,
  input  logic [DIM_WIDTH-1:0]  channels,
  input  logic [4:0]            avg_shift,
  input  logic [ADDR_WIDTH-1:0] in_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_ready,
  input  logic                  rd_rvalid,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PW = DIM_WIDTH + 2;

  state_t state, next_state;

  logic                   mode_q;
  logic [DIM_WIDTH-1:0]   k_q, s_q, h_q, w_q, c_q;
  logic [4:0]             shift_q;
  logic [ADDR_WIDTH-1:0]  in_base_q, out_base_q;
  logic [ADDR_WIDTH-1:0]  plane_size, row_step;
  logic [ADDR_WIDTH-1:0]  plane_addr, band_addr, win_addr, row_addr, out_addr;
  logic [DIM_WIDTH-1:0]   c_cnt, oy_pos, ox_pos, wy_cnt, wx_cnt;
  logic                   err_q;
  logic [2*DIM_WIDTH-1:0] area, band_step;
  logic [ADDR_WIDTH-1:0]  s_step, w_step;
  logic                   cfg_bad, last_wx, last_wy, win_done;
  logic                   next_col_ok, next_row_ok, next_ch_ok, last_win;
  logic                   acc_en, acc_first, acc_clear;
  logic [DATA_WIDTH-1:0]  acc_result;

  assign area      = h_q * w_q;
  assign band_step = s_q * w_q;
  assign s_step    = ADDR_WIDTH'(s_q);
  assign w_step    = ADDR_WIDTH'(w_q);

  assign cfg_bad = (k_q == '0) || (s_q == '0) || (c_q == '0) || (k_q > h_q) || (k_q > w_q);

  assign last_wx  = (wx_cnt == k_q - DIM_WIDTH'(1));
  assign last_wy  = (wy_cnt == k_q - DIM_WIDTH'(1));
  assign win_done = last_wx && last_wy;

  // A further window exists only if it would still lie fully inside the map.
  assign next_col_ok = ({2'b00, ox_pos} + {2'b00, s_q} + {2'b00, k_q}) <= PW'(w_q);
  assign next_row_ok = ({2'b00, oy_pos} + {2'b00, s_q} + {2'b00, k_q}) <= PW'(h_q);
  assign next_ch_ok  = (c_cnt + DIM_WIDTH'(1)) < c_q;
  assign last_win    = !next_col_ok && !next_row_ok && !next_ch_ok;

  assign acc_clear = (state == ST_SETUP);
  assign acc_en    = (state == ST_RD_WAIT) && rd_rvalid;
  assign acc_first = (wx_cnt == '0) && (wy_cnt == '0);

  pool_window_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .en     (acc_en),
    .first  (acc_first),
    .mode   (mode_q),
    .shift  (shift_q),
    .data   (rd_rdata),
    .result (acc_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = ST_SETUP;
      ST_SETUP:   next_state = cfg_bad ? ST_DONE : ST_RD_REQ;
      ST_RD_REQ:  if (rd_ready) next_state = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_rvalid) next_state = win_done ? ST_WRITE : ST_RD_REQ;
      ST_WRITE:   if (wr_ready) next_state = last_win ? ST_DONE : ST_RD_REQ;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Address registers walk incrementally: plane -> window row band -> window -> element row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= POOL_MAX;
      k_q        <= '0;
      s_q        <= '0;
      h_q        <= '0;
      w_q        <= '0;
      c_q        <= '0;
      shift_q    <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      plane_size <= '0;
      row_step   <= '0;
      plane_addr <= '0;
      band_addr  <= '0;
      win_addr   <= '0;
      row_addr   <= '0;
      out_addr   <= '0;
      c_cnt      <= '0;
      oy_pos     <= '0;
      ox_pos     <= '0;
      wy_cnt     <= '0;
      wx_cnt     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            k_q        <= pool_size;
            s_q        <= stride;
            h_q        <= in_h;
            w_q        <= in_w;
            c_q        <= channels;
            shift_q    <= avg_shift;
            in_base_q  <= in_base;
            out_base_q <= out_base;
            err_q      <= 1'b0;
          end
        end
        ST_SETUP: begin
          err_q      <= cfg_bad;
          plane_size <= ADDR_WIDTH'(area);
          row_step   <= ADDR_WIDTH'(band_step);
          plane_addr <= in_base_q;
          band_addr  <= in_base_q;
          win_addr   <= in_base_q;
          row_addr   <= in_base_q;
          out_addr   <= out_base_q;
          c_cnt      <= '0;
          oy_pos     <= '0;
          ox_pos     <= '0;
          wy_cnt     <= '0;
          wx_cnt     <= '0;
        end
        ST_RD_WAIT: begin
          if (rd_rvalid) begin
            if (!last_wx) begin
              wx_cnt <= wx_cnt + DIM_WIDTH'(1);
            end else if (!last_wy) begin
              wx_cnt   <= '0;
              wy_cnt   <= wy_cnt + DIM_WIDTH'(1);
              row_addr <= row_addr + w_step;
            end
          end
        end
        ST_WRITE: begin
          if (wr_ready) begin
            out_addr <= out_addr + ADDR_WIDTH'(1);
            wx_cnt   <= '0;
            wy_cnt   <= '0;
            if (next_col_ok) begin
              ox_pos   <= ox_pos + s_q;
              win_addr <= win_addr + s_step;
              row_addr <= win_addr + s_step;
            end else if (next_row_ok) begin
              ox_pos    <= '0;
              oy_pos    <= oy_pos + s_q;
              band_addr <= band_addr + row_step;
              win_addr  <= band_addr + row_step;
              row_addr  <= band_addr + row_step;
            end else if (next_ch_ok) begin
              ox_pos     <= '0;
              oy_pos     <= '0;
              c_cnt      <= c_cnt + DIM_WIDTH'(1);
              plane_addr <= plane_addr + plane_size;
              band_addr  <= plane_addr + plane_size;
              win_addr   <= plane_addr + plane_size;
              row_addr   <= plane_addr + plane_size;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state so an asynchronous reset zeroes them immediately.
  assign rd_req  = (state == ST_RD_REQ);
  assign rd_addr = rd_req ? (row_addr + ADDR_WIDTH'(wx_cnt)) : '0;
  assign wr_en   = (state == ST_WRITE);
  assign wr_addr = wr_en ? out_addr : '0;
  assign wr_data = wr_en ? acc_result : '0;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign err     = err_q;

endmodule

// File: tb/tb_pool2d_engine.sv
// Directed bench for pool2d_engine with a stallable, variable-latency memory responder.
module tb_pool2d_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [7:0]  pool_size, stride, in_h, in_w, channels;
  logic [4:0]  avg_shift;
  logic [11:0] in_base, out_base;
  logic        rd_req;
  logic [11:0] rd_addr;
  logic        rd_ready;
  logic        rd_rvalid;
  logic [31:0] rd_rdata;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        busy, done, err;

  pool2d_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .pool_size (pool_size),
    .stride    (stride),
    .in_h      (in_h),
    .in_w      (in_w),
    .channels  (channels),
    .avg_shift (avg_shift),
    .in_base   (in_base),
    .out_base  (out_base),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rd_rvalid (rd_rvalid),
    .rd_rdata  (rd_rdata),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [31:0] mem [0:4095];
  wr_t         wr_q[$];
  wr_t         ref_q[$];
  int          exp_q[$];
  int          n_checks;
  int          n_fail;
  int          rd_cnt;
  logic        stall_en;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: everything is decided on the falling edge for the next rising edge.
  initial begin
    pend      = 1'b0;
    pend_cnt  = 0;
    pend_data = '0;
    rd_ready  = 1'b0;
    rd_rvalid = 1'b0;
    rd_rdata  = '0;
    wr_ready  = 1'b0;
    forever begin
      @(negedge clk);
      rd_rvalid = 1'b0;
      rd_rdata  = '0;
      if (!rst_n) begin
        pend     = 1'b0;
        rd_ready = 1'b0;
        wr_ready = 1'b0;
      end else begin
        if (pend) begin
          if (pend_cnt == 0) begin
            rd_rvalid = 1'b1;
            rd_rdata  = pend_data;
            pend      = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        rd_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        wr_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (rd_req && rd_ready) begin
          pend      = 1'b1;
          pend_data = mem[rd_addr];
          pend_cnt  = stall_en ? int'($urandom_range(0, 3)) : 0;
          rd_cnt++;
        end
        if (wr_en && wr_ready) wr_q.push_back('{wr_addr, wr_data});
      end
    end
  end

  task automatic fill_map(input int base, input int n, input int first, input int step);
    for (int i = 0; i < n; i++) mem[base + i] = 32'(first + step * i);
  endtask

  task automatic run_job(input logic m, input int k, input int s, input int h, input int w,
                         input int c, input int sh, input int ib, input int ob,
                         input logic exp_err);
    int   pulses;
    logic got_err;
    pulses  = 0;
    got_err = 1'b0;
    wr_q.delete();
    @(negedge clk);
    mode      = m;
    pool_size = 8'(k);
    stride    = 8'(s);
    in_h      = 8'(h);
    in_w      = 8'(w);
    channels  = 8'(c);
    avg_shift = 5'(sh);
    in_base   = 12'(ib);
    out_base  = 12'(ob);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    pool_size = 8'd7;
    in_w      = 8'd1;
    out_base  = 12'hABC;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        got_err = err;
      end else if (pulses > 0) begin
        break;
      end
    end
    check_eq("done_pulses", 32'(pulses), 32'd1);
    check_eq("job_err", {31'b0, got_err}, {31'b0, exp_err});
  endtask

  task automatic check_writes(input string tag, input int ob);
    int n;
    check_eq({tag, "_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_addr"}, {20'b0, wr_q[i].addr}, 32'(ob + i));
      check_eq({tag, "_data"}, wr_q[i].data, 32'(exp_q[i]));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rd_cnt    = 0;
    stall_en  = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    pool_size = '0;
    stride    = '0;
    in_h      = '0;
    in_w      = '0;
    channels  = '0;
    avg_shift = '0;
    in_base   = '0;
    out_base  = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {27'b0, rd_req, wr_en, busy, done, err}, 32'd0);
    check_eq("rst_addr", {8'b0, rd_addr, wr_addr}, 32'd0);
    check_eq("rst_data", wr_data, 32'd0);
    rst_n = 1'b1;

    fill_map(100, 16, 0, 1);
    run_job(1'b0, 2, 2, 4, 4, 1, 0, 100, 2000, 1'b0);
    exp_q = {5, 7, 13, 15};
    check_writes("max_pos", 2000);

    fill_map(100, 16, -1, -1);
    run_job(1'b0, 2, 2, 4, 4, 1, 0, 100, 2000, 1'b0);
    exp_q = {-1, -3, -9, -11};
    check_writes("max_neg", 2000);

    fill_map(100, 32, 0, 1);
    run_job(1'b1, 2, 2, 4, 4, 2, 2, 100, 3000, 1'b0);
    exp_q = {2, 4, 10, 12, 18, 20, 26, 28};
    check_writes("avg_2ch", 3000);

    fill_map(200, 25, 0, 1);
    run_job(1'b0, 3, 1, 5, 5, 1, 0, 200, 1000, 1'b0);
    exp_q = {12, 13, 14, 17, 18, 19, 22, 23, 24};
    check_writes("overlap", 1000);
    ref_q = wr_q;

    fill_map(300, 20, 0, 1);
    run_job(1'b0, 2, 2, 5, 4, 1, 0, 300, 1500, 1'b0);
    exp_q = {5, 7, 13, 15};
    check_writes("drop_edge", 1500);

    // Config error: SETUP then DONE, with no read traffic.
    begin
      int rd0;
      rd0 = rd_cnt;
      @(negedge clk);
      mode      = 1'b0;
      pool_size = 8'd0;
      stride    = 8'd1;
      in_h      = 8'd4;
      in_w      = 8'd4;
      channels  = 8'd1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("kerr_setup", {30'b0, busy, done}, 32'b10);
      @(negedge clk);
      check_eq("kerr_done", {30'b0, done, err}, 32'b11);
      @(negedge clk);
      check_eq("kerr_after", {29'b0, busy, done, err}, 32'b001);
      check_eq("kerr_no_rd", 32'(rd_cnt), 32'(rd0));
    end

    stall_en = 1'b1;
    fill_map(200, 25, 0, 1);
    run_job(1'b0, 3, 1, 5, 5, 1, 0, 200, 1000, 1'b0);
    exp_q = {12, 13, 14, 17, 18, 19, 22, 23, 24};
    check_writes("stall_overlap", 1000);
    check_eq("stall_vs_ref_count", 32'(wr_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < wr_q.size() && i < ref_q.size(); i++)
      check_eq("stall_vs_ref_data", wr_q[i].data, ref_q[i].data);

    fill_map(100, 32, 0, 1);
    run_job(1'b1, 2, 2, 4, 4, 2, 2, 100, 3000, 1'b0);
    exp_q = {2, 4, 10, 12, 18, 20, 26, 28};
    check_writes("stall_avg", 3000);
    stall_en = 1'b0;

    // Abort mid-job with reset, then run cleanly again.
    fill_map(100, 16, 0, 1);
    @(negedge clk);
    mode      = 1'b0;
    pool_size = 8'd2;
    stride    = 8'd2;
    in_h      = 8'd4;
    in_w      = 8'd4;
    channels  = 8'd1;
    in_base   = 12'd100;
    out_base  = 12'd2000;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ctrl", {27'b0, rd_req, wr_en, busy, done, err}, 32'd0);
    check_eq("mid_rst_addr", {8'b0, rd_addr, wr_addr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_job(1'b0, 2, 2, 4, 4, 1, 0, 100, 2000, 1'b0);
    exp_q = {5, 7, 13, 15};
    check_writes("restart", 2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
